// File: rtl/eq_arb_pkg.sv
// Shared types and helpers for the round-robin equality-compare scheduler.
// The localparams here match the top-level parameter defaults.
package eq_arb_pkg;

    localparam int N_DEF       = 32;
    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);

    typedef struct packed {
        logic                valid;
        logic [ID_W_DEF-1:0] id;
        logic [N_DEF-1:0]    a;
        logic [N_DEF-1:0]    b;
    } stage1_t;

    typedef struct packed {
        logic                valid;
        logic [ID_W_DEF-1:0] id;
        logic                eq;
    } stage2_t;

    function automatic logic [NUM_REQ_DEF-1:0] onehot(input logic [ID_W_DEF-1:0] id);
        logic [NUM_REQ_DEF-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // First eligible requester at or after ptr, wrapping; returns a one-hot grant.
    function automatic logic [NUM_REQ_DEF-1:0] rr_pick(input logic [NUM_REQ_DEF-1:0] elig,
                                                       input logic [ID_W_DEF-1:0]    ptr);
        logic [NUM_REQ_DEF-1:0] g;
        logic                   found;
        logic [ID_W_DEF-1:0]    idx;
        g     = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NUM_REQ_DEF; k++) begin
            if (!found && elig[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
            idx = (idx == ID_W_DEF'(NUM_REQ_DEF - 1)) ? '0 : idx + 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/equality_check.sv
// N-bit equality comparator with both polarities.
module equality_check #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq,
    output logic         neq
);

    assign eq  = (a == b);
    assign neq = ~eq;

endmodule

// File: rtl/eq_compare_arbiter.sv
// Round-robin scheduler sharing one equality_check between NUM_REQ requesters,
// two-stage pipeline (S1 operands, S2 result), per-requester flush, no response backpressure.
module eq_compare_arbiter
    import eq_arb_pkg::*;
#(
    parameter  int N       = N_DEF,
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [N-1:0]       req_a [NUM_REQ],
    input  logic [N-1:0]       req_b [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [NUM_REQ-1:0] flush,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_eq,
    output logic               rsp_neq
);

    // Handshake: requester i transfers when req_valid[i] & req_ready[i]; responses
    // are strobes that must be consumed the cycle rsp_valid[i] is high.

    stage1_t             s1_q, s1_d;
    stage2_t             s2_q, s2_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     gid;
    logic                cmp_eq, cmp_neq;
    logic                s2_live;

    always_comb begin
        grant = reset ? '0 : rr_pick(req_valid & ~flush, ptr_q);
        gid   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gid = ID_W'(i);
        end
    end

    assign req_ready = grant;

    equality_check #(.N(N)) u_eq (
        .a   (s1_q.a),
        .b   (s1_q.b),
        .eq  (cmp_eq),
        .neq (cmp_neq)
    );

    always_comb begin
        s1_d  = '0;
        ptr_d = ptr_q;
        if (|grant) begin
            s1_d.valid = 1'b1;
            s1_d.id    = gid;
            s1_d.a     = req_a[gid];
            s1_d.b     = req_b[gid];
            ptr_d      = (gid == ID_W'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
        end
        // A flush of the S1 owner kills it on its way into S2.
        s2_d.valid = s1_q.valid & ~flush[s1_q.id];
        s2_d.id    = s1_q.id;
        s2_d.eq    = cmp_eq & ~cmp_neq;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            ptr_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            ptr_q <= ptr_d;
        end
    end

    // The presented response is suppressed by a same-cycle flush of its owner or by reset.
    assign s2_live   = s2_q.valid & ~flush[s2_q.id] & ~reset;
    assign rsp_valid = s2_live ? onehot(s2_q.id) : '0;
    assign rsp_id    = s2_live ? s2_q.id : '0;
    assign rsp_eq    = s2_live & s2_q.eq;
    assign rsp_neq   = s2_live & ~s2_q.eq;

endmodule

// File: tb/tb_eq_compare_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level reference (grant rotation + queue of due responses).
module tb_eq_compare_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_a [4];
  logic [31:0] req_b [4];
  logic [3:0]  req_ready;
  logic [3:0]  flush;
  logic [3:0]  rsp_valid;
  logic [1:0]  rsp_id;
  logic        rsp_eq;
  logic        rsp_neq;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  id;
    logic        eq;
  } exp_t;

  exp_t exp_q[$];

  eq_compare_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_eq    (rsp_eq),
    .rsp_neq   (rsp_neq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic clr_inputs();
    req_valid = '0;
    flush     = '0;
    for (int i = 0; i < 4; i++) begin
      req_a[i] = '0;
      req_b[i] = '0;
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clr_inputs();
    for (int i = 0; i < n; i++) next();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clr_inputs();
    next();
    req_valid = 4'b1111;
    #1;
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    tests_run++;
    if (rsp_valid !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid);
    end
    next();
    reset = 1'b0;
    clr_inputs();
    #1;
    tests_run++;
    if ({rsp_valid, rsp_id, rsp_eq, rsp_neq} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b id=%0d eq=%b neq=%b want all 0",
               rsp_valid, rsp_id, rsp_eq, rsp_neq);
    end
  endtask

  task automatic test_single_match();
    req_valid = 4'b0001;
    req_a[0]  = 32'hDEADBEEF;
    req_b[0]  = 32'hDEADBEEF;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    next();
    clr_inputs();
    #1;
    tests_run++;
    if (rsp_valid !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_early_rsp: got %b want 0000", rsp_valid);
    end
    next();
    tests_run++;
    if (rsp_valid !== 4'b0001 || rsp_id !== 2'd0 || rsp_eq !== 1'b1 || rsp_neq !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_rsp: got v=%b id=%0d eq=%b neq=%b want v=0001 id=0 eq=1 neq=0",
               rsp_valid, rsp_id, rsp_eq, rsp_neq);
    end
    next();
    tests_run++;
    if (rsp_valid !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_rsp_drop: got %b want 0000", rsp_valid);
    end
  endtask

  task automatic test_mismatch_walk();
    logic [31:0] r;
    req_valid = 4'b0100;
    req_a[2]  = 32'h1;
    req_b[2]  = 32'h80000001;
    #1;
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL mismatch_ready: got %b want 0100", req_ready);
    end
    next();
    clr_inputs();
    next();
    tests_run++;
    if (rsp_valid !== 4'b0100 || rsp_id !== 2'd2 || rsp_eq !== 1'b0 || rsp_neq !== 1'b1) begin
      tests_failed++;
      $display("FAIL mismatch_rsp: got v=%b id=%0d eq=%b neq=%b want v=0100 id=2 eq=0 neq=1",
               rsp_valid, rsp_id, rsp_eq, rsp_neq);
    end
    // one differing bit per cycle, back-to-back
    for (int k = 0; k < 34; k++) begin
      clr_inputs();
      if (k < 32) begin
        r         = $urandom;
        req_valid = 4'b0100;
        req_a[2]  = r;
        req_b[2]  = r ^ (32'h1 << k);
      end
      #1;
      if (k < 32) begin
        tests_run++;
        if (req_ready !== 4'b0100) begin
          tests_failed++;
          $display("FAIL walk_ready[%0d]: got %b want 0100", k, req_ready);
        end
      end
      if (k >= 2) begin
        tests_run++;
        if (rsp_valid !== 4'b0100 || rsp_eq !== 1'b0 || rsp_neq !== 1'b1) begin
          tests_failed++;
          $display("FAIL walk_rsp[bit %0d]: got v=%b eq=%b neq=%b want v=0100 eq=0 neq=1",
                   k - 2, rsp_valid, rsp_eq, rsp_neq);
        end
      end
      next();
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_v;
    int         eid;
    reset = 1'b1;
    clr_inputs();
    next();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      clr_inputs();
      if (k < 8) begin
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
          req_a[i] = 32'h1000 * (i + 1) + k;
          req_b[i] = (i % 2 == 0) ? req_a[i] : req_a[i] + 32'h1;
        end
      end
      #1;
      exp_v = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      tests_run++;
      if (req_ready !== exp_v) begin
        tests_failed++;
        $display("FAIL fair_grant[%0d]: got %b want %b", k, req_ready, exp_v);
      end
      if (k >= 2) begin
        eid   = (k - 2) % 4;
        exp_v = 4'b0001 << eid;
        tests_run++;
        if (rsp_valid !== exp_v || rsp_id !== 2'(eid) || rsp_eq !== (eid % 2 == 0)) begin
          tests_failed++;
          $display("FAIL fair_rsp[%0d]: got v=%b id=%0d eq=%b want v=%b id=%0d eq=%b",
                   k, rsp_valid, rsp_id, rsp_eq, exp_v, eid, (eid % 2 == 0));
        end
      end else begin
        tests_run++;
        if (rsp_valid !== 4'b0000) begin
          tests_failed++;
          $display("FAIL fair_rsp_early[%0d]: got %b want 0000", k, rsp_valid);
        end
      end
      next();
    end
  endtask

  task automatic test_wrap();
    // pointer is 0 here; a grant to 2 moves it to 3
    clr_inputs();
    req_valid = 4'b0100;
    req_a[2]  = 32'h5;
    req_b[2]  = 32'h5;
    #1;
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL wrap_pre: got %b want 0100", req_ready);
    end
    next();
    req_valid = 4'b1001;
    #1;
    tests_run++;
    if (req_ready !== 4'b1000) begin
      tests_failed++;
      $display("FAIL wrap_grant3: got %b want 1000", req_ready);
    end
    next();
    req_valid = 4'b1001;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL wrap_grant0: got %b want 0001", req_ready);
    end
    tests_run++;
    if (rsp_valid !== 4'b0100 || rsp_id !== 2'd2 || rsp_eq !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_rsp: got v=%b id=%0d eq=%b want v=0100 id=2 eq=1",
               rsp_valid, rsp_id, rsp_eq);
    end
    next();
    idle(3);
  endtask

  task automatic test_flush();
    // pointer is 1 here
    clr_inputs();
    req_valid = 4'b0010;
    #1;
    tests_run++;
    if (req_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL flush_t_grant: got %b want 0010", req_ready);
    end
    next();
    req_valid = 4'b0100;
    flush     = 4'b0010;
    req_a[2]  = 32'hA5A5A5A5;
    req_b[2]  = 32'hA5A5A5A5;
    #1;
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL flush_t1_grant: got %b want 0100", req_ready);
    end
    next();
    clr_inputs();
    #1;
    tests_run++;
    if (rsp_valid !== 4'b0000) begin
      tests_failed++;
      $display("FAIL flush_s1_kill: got %b want 0000", rsp_valid);
    end
    next();
    tests_run++;
    if (rsp_valid !== 4'b0100 || rsp_id !== 2'd2 || rsp_eq !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_survivor: got v=%b id=%0d eq=%b want v=0100 id=2 eq=1",
               rsp_valid, rsp_id, rsp_eq);
    end
    // pointer is 3: grant 3, then flush it while it sits in S2
    next();
    req_valid = 4'b1000;
    #1;
    tests_run++;
    if (req_ready !== 4'b1000) begin
      tests_failed++;
      $display("FAIL flush_u_grant: got %b want 1000", req_ready);
    end
    next();
    clr_inputs();
    req_valid = 4'b0001;
    flush     = 4'b0001;
    req_a[0]  = 32'h77;
    req_b[0]  = 32'h77;
    #1;
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL flush_same_cycle: got %b want 0000", req_ready);
    end
    next();
    req_valid = 4'b0011;
    flush     = 4'b1000;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL flush_ptr_hold: got %b want 0001", req_ready);
    end
    tests_run++;
    if (rsp_valid !== 4'b0000 || rsp_id !== 2'd0 || rsp_neq !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_s2_kill: got v=%b id=%0d neq=%b want v=0000 id=0 neq=0",
               rsp_valid, rsp_id, rsp_neq);
    end
    next();
    clr_inputs();
    #1;
    tests_run++;
    if (rsp_valid !== 4'b0000) begin
      tests_failed++;
      $display("FAIL flush_no_phantom: got %b want 0000", rsp_valid);
    end
    next();
    tests_run++;
    if (rsp_valid !== 4'b0001 || rsp_id !== 2'd0 || rsp_eq !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_after: got v=%b id=%0d eq=%b want v=0001 id=0 eq=1",
               rsp_valid, rsp_id, rsp_eq);
    end
    idle(2);
  endtask

  task automatic test_reset_midflight();
    // pointer is 1 here
    clr_inputs();
    req_valid = 4'b0010;
    next();
    req_valid = 4'b0100;
    next();
    reset     = 1'b1;
    req_valid = 4'b1000;
    #1;
    tests_run++;
    if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midrst_during: got ready=%b rsp=%b want 0000 0000", req_ready, rsp_valid);
    end
    next();
    reset     = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 32'h42;
      req_b[i] = 32'h43;
    end
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL midrst_grant: got %b want 0001", req_ready);
    end
    tests_run++;
    if (rsp_valid !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midrst_drop1: got %b want 0000", rsp_valid);
    end
    next();
    clr_inputs();
    #1;
    tests_run++;
    if (rsp_valid !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midrst_drop2: got %b want 0000", rsp_valid);
    end
    next();
    tests_run++;
    if (rsp_valid !== 4'b0001 || rsp_id !== 2'd0 || rsp_neq !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_next: got v=%b id=%0d neq=%b want v=0001 id=0 neq=1",
               rsp_valid, rsp_id, rsp_neq);
    end
    idle(2);
  endtask

  task automatic test_random();
    logic [3:0]  pend;
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    int          ptr_m;
    int          g;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_v;
    logic [1:0]  exp_id;
    logic        exp_eq;
    logic        has_rsp;
    exp_t        nq[$];
    pend  = '0;
    ptr_m = 0;
    exp_q.delete();
    reset = 1'b1;
    clr_inputs();
    next();
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i]   = $urandom;
          pb[i]   = ($urandom_range(0, 1) == 0) ? pa[i] : pa[i] ^ (32'h1 << $urandom_range(0, 31));
        end
      end
      req_valid = pend;
      for (int i = 0; i < 4; i++) begin
        req_a[i] = pa[i];
        req_b[i] = pb[i];
        flush[i] = ($urandom_range(0, 9) == 0);
      end
      reset = ($urandom_range(0, 49) == 0);
      #1;
      // reference: cancel flushed in-flight work, then pick the next grant
      g = -1;
      if (reset) begin
        exp_q.delete();
      end else begin
        nq.delete();
        foreach (exp_q[j]) begin
          if (!(flush[exp_q[j].id] && exp_q[j].cyc >= 32'(c) && exp_q[j].cyc <= 32'(c + 1)))
            nq.push_back(exp_q[j]);
        end
        exp_q = nq;
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && pend[(ptr_m + k) % 4] && !flush[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
        end
      end
      exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      has_rsp   = (exp_q.size() > 0) && (exp_q[0].cyc == 32'(c));
      exp_v     = has_rsp ? (4'b0001 << exp_q[0].id) : 4'b0000;
      exp_id    = has_rsp ? exp_q[0].id : 2'd0;
      exp_eq    = has_rsp ? exp_q[0].eq : 1'b0;
      tests_run++;
      if (req_ready !== exp_ready) begin
        tests_failed++;
        $display("FAIL rand_ready[c%0d]: got %b want %b", c, req_ready, exp_ready);
      end
      tests_run++;
      if (rsp_valid !== exp_v || rsp_id !== exp_id || rsp_eq !== exp_eq
          || rsp_neq !== (has_rsp && !exp_eq)) begin
        tests_failed++;
        $display("FAIL rand_rsp[c%0d]: got v=%b id=%0d eq=%b neq=%b want v=%b id=%0d eq=%b",
                 c, rsp_valid, rsp_id, rsp_eq, rsp_neq, exp_v, exp_id, exp_eq);
      end
      if (has_rsp) void'(exp_q.pop_front());
      if (reset) begin
        ptr_m = 0;
      end else if (g >= 0) begin
        exp_q.push_back('{cyc: 32'(c + 2), id: 2'(g), eq: (pa[g] == pb[g])});
        pend[g] = 1'b0;
        ptr_m   = (g + 1) % 4;
      end
      next();
    end
    reset = 1'b0;
    idle(3);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    clr_inputs();
    test_reset();
    test_single_match();
    test_mismatch_walk();
    test_fairness();
    test_wrap();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/eq_compare_arbiter.md
# eq_compare_arbiter

Round-robin scheduler that shares one `equality_check` comparator (N-bit, `eq`/`neq` outputs) between `NUM_REQ` requesters, typically the branch-resolution stages of the cores in the multi-core MIPS machine. It grants one request per cycle, carries the operands and requester ID through a two-stage pipeline, and returns a tagged result. Responses have no backpressure. A per-requester flush cancels that requester's in-flight work.

## Interface
- `N`, 32, operand width passed to `equality_check`
- `NUM_REQ`, 4, number of requesters (≥2)
- `ID_W`, `$clog2(NUM_REQ)`, requester-ID width (derived, not overridden)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  request pending, one bit per requester
- `req_a`  in  [N-1:0] x NUM_REQ  operand A per requester (unpacked array)
- `req_b`  in  [N-1:0] x NUM_REQ  operand B per requester
- `req_ready`  out  NUM_REQ  one-hot grant; handshake when `req_valid[i] & req_ready[i]`
- `flush`  in  NUM_REQ  cancel in-flight work for requester i
- `rsp_valid`  out  NUM_REQ  one-hot response strobe
- `rsp_id`  out  ID_W  ID of the responding requester
- `rsp_eq`  out  1  a == b for the responding request
- `rsp_neq`  out  1  a != b, always `~rsp_eq` while any `rsp_valid` bit is set

## Operation
- Arbitration is combinational from `req_valid`, `flush` and the priority pointer `ptr`.
  - Search order is ptr, ptr+1, …, wrapping modulo `NUM_REQ`.
  - The first requester with `req_valid[i] & ~flush[i]` gets `req_ready[i]=1`.
  - At most one `req_ready` bit is set per cycle.
- On a handshake with requester g:
  - S1 captures `{valid=1, id=g, a=req_a[g], b=req_b[g]}`.
  - `ptr` becomes `(g+1) mod NUM_REQ`.
  - With no handshake, `ptr` holds and S1.valid is 0.
- S1 operands drive the single `equality_check` instance.
- S2 captures `{valid, id, eq}` from S1 each cycle.
- Outputs come from S2:
  - `rsp_valid = S2.valid ? onehot(S2.id) : 0`
  - `rsp_id = S2.id`, `rsp_eq = S2.eq`, `rsp_neq = ~S2.eq`
  - When S2.valid is 0, `rsp_id`, `rsp_eq` and `rsp_neq` are 0.
- Flush of requester i:
  - Clears S1.valid if S1.id == i. Clears S2.valid if S2.id == i (S2 is the response currently being presented).
  - Masks requester i from arbitration in the same cycle.
  - Flush of other IDs has no effect on a stage.
- Requesters hold `req_valid`, `req_a` and `req_b` stable until granted. The block does not check this.
- Responses carry no backpressure. The requester consumes `rsp_*` in the cycle `rsp_valid[i]` is high.

## Timing
- Reset values:
  - `ptr` = 0
  - S1.valid = S2.valid = 0, all payload registers 0
  - outputs: `req_ready` follows the arbiter; `rsp_valid` = 0, `rsp_id` = 0, `rsp_eq` = 0, `rsp_neq` = 0
- During reset, `req_ready` is forced to 0. No handshake occurs in a reset cycle.
- Latency: a handshake at edge T produces `rsp_valid` during the cycle after edge T+1, i.e. 2 cycles.
- Throughput is one request per cycle, sustained.
- A requester re-raising `req_valid` right after its grant is not starved. With all requesters active, grants rotate 0,1,2,3,0,…
- Pointer wrap: a grant to `NUM_REQ-1` sets `ptr` to 0.
- Reset mid-operation drops S1 and S2 contents. No response is emitted for those requests.
- Flush and handshake for the same i in the same cycle: no grant to i, and the pointer does not move on i's account.
- Flush of the S2 ID in the cycle S2 would present: `rsp_valid` is 0 that cycle.

## Structure
- `eq_arb_pkg` holds:
  - a `stage1_t` struct `{valid, id, a, b}`
  - a `stage2_t` struct `{valid, id, eq}`
  - a `onehot`/`rr_pick` helper function
- The package is parameterised through localparams matching the defaults. The module uses the `N` and `NUM_REQ` overrides.
- One sub-module instance: the existing `equality_check #(.N(N))`. It is instantiated, not reimplemented.
- The round-robin picker stays inline as a function. No separate module.

## Test plan
- Reset, then a single request: `req_valid=4'b0001`, a=b=32'hDEADBEEF.
  - `req_ready=0001` immediately.
  - 2 cycles later `rsp_valid=0001`, `rsp_id=0`, `rsp_eq=1`, `rsp_neq=0`.
- Mismatch: requester 2, a=32'h1, b=32'h80000001.
  - Response `rsp_id=2`, `rsp_eq=0`, `rsp_neq=1`.
  - Walk a single differing bit across all N positions; each gives `neq=1`.
- Fairness: all four requesters held valid for 8 cycles.
  - Grants are 0,1,2,3,0,1,2,3.
  - Responses follow in the same order, back-to-back.
- Pointer wrap: grant to 3 with requesters 0 and 3 valid.
  - Next grant goes to 0. `ptr` reads 0 after the wrap.
- Flush: request from 1 granted at T, `flush[1]` at T+1.
  - No response for 1.
  - A request from 2 granted at T+1 still responds at T+3.
- Reset mid-flight: two requests in S1/S2 when `reset` is asserted for 1 cycle.
  - No `rsp_valid` afterwards.
  - The next grant after reset goes to requester 0.
